exc_collect: RTL and testbench
==============================

Name: exc_collect

Overview:
- Exception collector in the MEM stage; the producing end of the CP0 exception interface.
- Per cycle, merges per-instruction exception flags, synchronised external interrupt lines and ERET into one prioritised report.
- Report is exccode/pc/in_delay/badvaddr, presented registered to the CP0 register block.
- Squashes reports while the pipeline flush triggered by a previous report is still draining.

Parameters:
SYNC_STAGES, 2, flip-flop stages on each int_raw_i bit (legal 2..4)
SQUASH_CYCLES, 2, cycles after any reported event during which new reports are suppressed (legal 1..7)
ERET_BLANK, 3, cycles after a reported ERET during which interrupts are not taken (legal 0..7)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
inst_valid_i  input  1  MEM holds a real instruction (0 = bubble)
pc_i  input  32  PC of MEM instruction
in_delay_i  input  1  MEM instruction is in a branch delay slot
mem_addr_i  input  32  data address of MEM load/store
exc_fetch_adel_i  input  1  fetch address error
exc_ri_i  input  1  reserved instruction
exc_ov_i  input  1  arithmetic overflow
exc_syscall_i  input  1  syscall
exc_break_i  input  1  break
exc_load_adel_i  input  1  load address error
exc_store_ades_i  input  1  store address error
eret_i  input  1  MEM instruction is ERET
int_raw_i  input  6  asynchronous hardware interrupt lines
cp0_status_i  input  32  current CP0 Status
cp0_cause_i  input  32  current CP0 Cause
cp0_we_i  input  1  MTC0 in flight this cycle
cp0_waddr_i  input  5  MTC0 target register
cp0_wdata_i  input  32  MTC0 data
exccode_o  output  5  0x10 none, 0x11 ERET, else MIPS ExcCode
pc_o  output  32  PC of reported instruction
in_delay_o  output  1  reported instruction in delay slot
badvaddr_o  output  32  faulting address (valid with codes 4/5)
int_sync_o  output  6  synchronised interrupt lines, to CP0 int_i
mem_cancel_o  output  1  combinational: suppress MEM store/load side effects this cycle
busy_o  output  1  FSM not in RUN

Behaviour:
- Reset (rst_n=0 at posedge): exccode_o=0x10, pc_o=0, in_delay_o=0, badvaddr_o=0, int_sync_o=0, sync chain cleared, FSM=RUN, counters=0, busy_o=0.
- int_sync_o is the last stage of the SYNC_STAGES chain. An int_raw_i edge appears on int_sync_o exactly SYNC_STAGES cycles later.
- Effective Status/Cause (forwarding):
  - st = cp0_wdata_i when cp0_we_i && waddr==12, else cp0_status_i.
  - ca[9:8] = cp0_wdata_i[9:8] when cp0_we_i && waddr==13, else cp0_cause_i[9:8].
  - ca[15:10] = int_sync_o.
- int_pend = st[0] && !st[1] && |(ca[15:8] & st[15:8]) && blank_cnt==0.
- Candidate, evaluated only when FSM=RUN and inst_valid_i=1. Priority high to low:
  - int_pend -> 0x00
  - fetch_adel -> 0x04, badvaddr=pc_i
  - ri -> 0x0A
  - ov -> 0x0C
  - syscall -> 0x08
  - break -> 0x09
  - load_adel -> 0x04, badvaddr=mem_addr_i
  - store_ades -> 0x05, badvaddr=mem_addr_i
  - eret -> 0x11
  - none -> 0x10
- Interrupts are never attached to a bubble: with inst_valid_i=0, int_pend stays pending and is taken on the next valid instruction.
- mem_cancel_o = 1 whenever the candidate != 0x10. It is combinational, same cycle.
- Registered report, latency 1: at the posedge, exccode_o <= candidate, pc_o <= pc_i, in_delay_o <= in_delay_i. badvaddr_o updates only for codes 4/5 and otherwise holds.
- exccode_o is a one-cycle pulse: the next cycle it returns to 0x10 unless a new report is made.
- FSM RUN -> SQUASH when candidate != 0x10. sq_cnt loads SQUASH_CYCLES.
- In SQUASH:
  - candidate forced to 0x10, mem_cancel_o=1, busy_o=1.
  - sq_cnt decrements each cycle; return to RUN the cycle after sq_cnt reaches 1.
- blank_cnt loads ERET_BLANK when an ERET is reported. It decrements in any state and saturates at 0.
- Simultaneous exception + ERET: the exception wins and blank_cnt is not loaded.
- Interrupt + synchronous fault on the same instruction: code 0x00 reported, badvaddr_o unchanged.
- Reset asserted mid-SQUASH: immediate return to reset values next edge, no residual squash.

Test Plan:
- Reset: hold rst_n=0 3 cycles, release -> exccode_o=0x10, busy_o=0, all other outputs 0.
- Overflow: inst_valid=1, pc_i=0x1000, exc_ov_i=1 -> next cycle exccode_o=0x0C, pc_o=0x1000, in_delay_o=0; busy_o=1 for 2 cycles; an ov flag in those cycles is not reported.
- Load address error in delay slot: mem_addr_i=0x2003, exc_load_adel_i=1, in_delay_i=1 -> exccode_o=0x04, badvaddr_o=0x2003, in_delay_o=1.
- Interrupt: Status=0x0000_0401, int_raw_i[0] rises -> int_sync_o[0]=1 after 2 cycles. With bubbles until cycle 5, report 0x00 with pc of the first valid instruction.
- Interrupt forwarding: same-cycle MTC0 Status=0x0000_0400 (IE=0) with a pending interrupt -> no interrupt taken.
- ERET: eret_i -> 0x11 reported. A pending interrupt is not taken until 3 cycles after the report; fetch_adel together with eret -> 0x04 reported.

Source files
------------

// File: rtl/exc_collect.sv
// MEM-stage exception collector: merges exception flags, synchronised interrupts
// and ERET into one prioritised, registered report for the CP0 register block.
//
// state  | meaning
// RUN    | evaluating the MEM instruction each cycle
// SQUASH | flush from the last report still draining; reports suppressed
module exc_collect #(
  parameter int SYNC_STAGES   = 2,
  parameter int SQUASH_CYCLES = 2,
  parameter int ERET_BLANK    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid_i,
  input  logic [31:0] pc_i,
  input  logic        in_delay_i,
  input  logic [31:0] mem_addr_i,
  input  logic        exc_fetch_adel_i,
  input  logic        exc_ri_i,
  input  logic        exc_ov_i,
  input  logic        exc_syscall_i,
  input  logic        exc_break_i,
  input  logic        exc_load_adel_i,
  input  logic        exc_store_ades_i,
  input  logic        eret_i,
  input  logic [5:0]  int_raw_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic        cp0_we_i,
  input  logic [4:0]  cp0_waddr_i,
  input  logic [31:0] cp0_wdata_i,
  output logic [4:0]  exccode_o,
  output logic [31:0] pc_o,
  output logic        in_delay_o,
  output logic [31:0] badvaddr_o,
  output logic [5:0]  int_sync_o,
  output logic        mem_cancel_o,
  output logic        busy_o
);

  localparam logic [4:0] CODE_INT  = 5'h00;
  localparam logic [4:0] CODE_ADEL = 5'h04;
  localparam logic [4:0] CODE_ADES = 5'h05;
  localparam logic [4:0] CODE_SYS  = 5'h08;
  localparam logic [4:0] CODE_BP   = 5'h09;
  localparam logic [4:0] CODE_RI   = 5'h0a;
  localparam logic [4:0] CODE_OV   = 5'h0c;
  localparam logic [4:0] CODE_NONE = 5'h10;
  localparam logic [4:0] CODE_ERET = 5'h11;

  localparam logic [2:0] SQ_LOAD    = 3'(SQUASH_CYCLES);
  localparam logic [2:0] BLANK_LOAD = 3'(ERET_BLANK);

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;

  typedef enum logic {
    ST_RUN,
    ST_SQUASH
  } state_t;

  state_t state_q, state_d;
  logic [2:0] sq_cnt_q, sq_cnt_d;
  logic [2:0] blank_cnt_q, blank_cnt_d;

  logic [SYNC_STAGES-1:0][5:0] sync_q;

  logic [31:0] st_eff;
  logic [1:0]  sw_ip;
  logic [7:0]  ip_eff;
  logic        int_pend;

  logic [4:0]  cand;
  logic [31:0] cand_bad;
  logic        cand_bad_we;

  logic unused_ok;

  // Plain shift chain; only the last stage is ever observed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], int_raw_i};
    end
  end

  assign int_sync_o = sync_q[SYNC_STAGES-1];

  // An MTC0 in flight must affect the interrupt decision in the same cycle.
  assign st_eff   = (cp0_we_i && cp0_waddr_i == ADDR_STATUS) ? cp0_wdata_i : cp0_status_i;
  assign sw_ip    = (cp0_we_i && cp0_waddr_i == ADDR_CAUSE) ? cp0_wdata_i[9:8] : cp0_cause_i[9:8];
  assign ip_eff   = {int_sync_o, sw_ip};
  assign int_pend = st_eff[0] && !st_eff[1] && (|(ip_eff & st_eff[15:8])) &&
                    (blank_cnt_q == 3'd0);

  assign unused_ok = ^{st_eff[31:16], st_eff[7:2], cp0_cause_i[31:10], cp0_cause_i[7:0]};

  always_comb begin
    cand        = CODE_NONE;
    cand_bad    = 32'd0;
    cand_bad_we = 1'b0;
    if (state_q == ST_RUN && inst_valid_i) begin
      if (int_pend) begin
        cand = CODE_INT;
      end else if (exc_fetch_adel_i) begin
        cand        = CODE_ADEL;
        cand_bad    = pc_i;
        cand_bad_we = 1'b1;
      end else if (exc_ri_i) begin
        cand = CODE_RI;
      end else if (exc_ov_i) begin
        cand = CODE_OV;
      end else if (exc_syscall_i) begin
        cand = CODE_SYS;
      end else if (exc_break_i) begin
        cand = CODE_BP;
      end else if (exc_load_adel_i) begin
        cand        = CODE_ADEL;
        cand_bad    = mem_addr_i;
        cand_bad_we = 1'b1;
      end else if (exc_store_ades_i) begin
        cand        = CODE_ADES;
        cand_bad    = mem_addr_i;
        cand_bad_we = 1'b1;
      end else if (eret_i) begin
        cand = CODE_ERET;
      end
    end
  end

  assign mem_cancel_o = (cand != CODE_NONE) || (state_q == ST_SQUASH);
  assign busy_o       = (state_q == ST_SQUASH);

  always_comb begin
    state_d  = state_q;
    sq_cnt_d = sq_cnt_q;
    if (state_q == ST_RUN) begin
      if (cand != CODE_NONE) begin
        state_d  = ST_SQUASH;
        sq_cnt_d = SQ_LOAD;
      end
    end else begin
      sq_cnt_d = (sq_cnt_q == 3'd0) ? 3'd0 : sq_cnt_q - 3'd1;
      if (sq_cnt_q <= 3'd1) begin
        state_d = ST_RUN;
      end
    end
  end

  // Blanking runs independently of the FSM so it also counts through SQUASH.
  always_comb begin
    blank_cnt_d = (blank_cnt_q == 3'd0) ? 3'd0 : blank_cnt_q - 3'd1;
    if (cand == CODE_ERET) begin
      blank_cnt_d = BLANK_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      sq_cnt_q    <= 3'd0;
      blank_cnt_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      sq_cnt_q    <= sq_cnt_d;
      blank_cnt_q <= blank_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exccode_o  <= CODE_NONE;
      pc_o       <= 32'd0;
      in_delay_o <= 1'b0;
      badvaddr_o <= 32'd0;
    end else begin
      exccode_o  <= cand;
      pc_o       <= pc_i;
      in_delay_o <= in_delay_i;
      if (cand_bad_we) begin
        badvaddr_o <= cand_bad;
      end
    end
  end

endmodule

// File: tb/tb_exc_collect.sv
// Self-checking bench for exc_collect: directed scenarios plus a randomized run
// against a cycle-level reference model of the reporting rules.
module tb_exc_collect;
  localparam int SYNC_STAGES   = 2;
  localparam int SQUASH_CYCLES = 2;
  localparam int ERET_BLANK    = 3;

  logic        clk;
  logic        rst_n;
  logic        inst_valid_i;
  logic [31:0] pc_i;
  logic        in_delay_i;
  logic [31:0] mem_addr_i;
  logic        exc_fetch_adel_i;
  logic        exc_ri_i;
  logic        exc_ov_i;
  logic        exc_syscall_i;
  logic        exc_break_i;
  logic        exc_load_adel_i;
  logic        exc_store_ades_i;
  logic        eret_i;
  logic [5:0]  int_raw_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic        cp0_we_i;
  logic [4:0]  cp0_waddr_i;
  logic [31:0] cp0_wdata_i;
  logic [4:0]  exccode_o;
  logic [31:0] pc_o;
  logic        in_delay_o;
  logic [31:0] badvaddr_o;
  logic [5:0]  int_sync_o;
  logic        mem_cancel_o;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;

  exc_collect #(
    .SYNC_STAGES(SYNC_STAGES),
    .SQUASH_CYCLES(SQUASH_CYCLES),
    .ERET_BLANK(ERET_BLANK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .inst_valid_i(inst_valid_i), .pc_i(pc_i),
    .in_delay_i(in_delay_i), .mem_addr_i(mem_addr_i),
    .exc_fetch_adel_i(exc_fetch_adel_i), .exc_ri_i(exc_ri_i), .exc_ov_i(exc_ov_i),
    .exc_syscall_i(exc_syscall_i), .exc_break_i(exc_break_i),
    .exc_load_adel_i(exc_load_adel_i), .exc_store_ades_i(exc_store_ades_i),
    .eret_i(eret_i), .int_raw_i(int_raw_i), .cp0_status_i(cp0_status_i),
    .cp0_cause_i(cp0_cause_i), .cp0_we_i(cp0_we_i), .cp0_waddr_i(cp0_waddr_i),
    .cp0_wdata_i(cp0_wdata_i), .exccode_o(exccode_o), .pc_o(pc_o),
    .in_delay_o(in_delay_o), .badvaddr_o(badvaddr_o), .int_sync_o(int_sync_o),
    .mem_cancel_o(mem_cancel_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_valid_i = 0; pc_i = 0; in_delay_i = 0; mem_addr_i = 0;
    exc_fetch_adel_i = 0; exc_ri_i = 0; exc_ov_i = 0; exc_syscall_i = 0;
    exc_break_i = 0; exc_load_adel_i = 0; exc_store_ades_i = 0; eret_i = 0;
    int_raw_i = 0; cp0_status_i = 0; cp0_cause_i = 0; cp0_we_i = 0;
    cp0_waddr_i = 0; cp0_wdata_i = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    repeat (3) tick();
    rst_n = 1;
    #1;
    checks++; if (exccode_o !== 5'h10) begin failures++; $display("FAIL reset_code got=%h exp=10", exccode_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if (pc_o !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h exp=0", pc_o); end
    checks++; if (in_delay_o !== 1'b0) begin failures++; $display("FAIL reset_dly got=%b exp=0", in_delay_o); end
    checks++; if (badvaddr_o !== 32'd0) begin failures++; $display("FAIL reset_bad got=%h exp=0", badvaddr_o); end
    checks++; if (int_sync_o !== 6'd0) begin failures++; $display("FAIL reset_sync got=%h exp=0", int_sync_o); end
    checks++; if (mem_cancel_o !== 1'b0) begin failures++; $display("FAIL reset_cancel got=%b exp=0", mem_cancel_o); end
  endtask

  task automatic test_overflow();
    clear_inputs();
    inst_valid_i = 1; pc_i = 32'h1000; exc_ov_i = 1;
    #1;
    checks++; if (mem_cancel_o !== 1'b1) begin failures++; $display("FAIL ovf_cancel got=%b exp=1", mem_cancel_o); end
    tick();
    checks++; if (exccode_o !== 5'h0c) begin failures++; $display("FAIL ovf_code got=%h exp=0c", exccode_o); end
    checks++; if (pc_o !== 32'h1000) begin failures++; $display("FAIL ovf_pc got=%h exp=1000", pc_o); end
    checks++; if (in_delay_o !== 1'b0) begin failures++; $display("FAIL ovf_dly got=%b exp=0", in_delay_o); end
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL ovf_busy1 got=%b exp=1", busy_o); end
    pc_i = 32'h1004;
    #1;
    checks++; if (mem_cancel_o !== 1'b1) begin failures++; $display("FAIL ovf_sq_cancel got=%b exp=1", mem_cancel_o); end
    tick();
    checks++; if (exccode_o !== 5'h10) begin failures++; $display("FAIL ovf_sq_code1 got=%h exp=10", exccode_o); end
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL ovf_busy2 got=%b exp=1", busy_o); end
    pc_i = 32'h1008;
    tick();
    checks++; if (exccode_o !== 5'h10) begin failures++; $display("FAIL ovf_sq_code2 got=%h exp=10", exccode_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL ovf_busy_end got=%b exp=0", busy_o); end
    clear_inputs();
    tick();
  endtask

  task automatic test_load_adel_delay();
    clear_inputs();
    inst_valid_i = 1; pc_i = 32'h2000; in_delay_i = 1;
    mem_addr_i = 32'h2003; exc_load_adel_i = 1;
    #1;
    checks++; if (mem_cancel_o !== 1'b1) begin failures++; $display("FAIL ladel_cancel got=%b exp=1", mem_cancel_o); end
    tick();
    checks++; if (exccode_o !== 5'h04) begin failures++; $display("FAIL ladel_code got=%h exp=04", exccode_o); end
    checks++; if (badvaddr_o !== 32'h2003) begin failures++; $display("FAIL ladel_bad got=%h exp=2003", badvaddr_o); end
    checks++; if (in_delay_o !== 1'b1) begin failures++; $display("FAIL ladel_dly got=%b exp=1", in_delay_o); end
    checks++; if (pc_o !== 32'h2000) begin failures++; $display("FAIL ladel_pc got=%h exp=2000", pc_o); end
    clear_inputs();
    repeat (2) tick();
    checks++; if (badvaddr_o !== 32'h2003) begin failures++; $display("FAIL ladel_hold got=%h exp=2003", badvaddr_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL ladel_busy got=%b exp=0", busy_o); end
  endtask

  task automatic test_interrupt();
    clear_inputs();
    cp0_status_i = 32'h0000_0401;
    int_raw_i = 6'b000001;
    tick();
    checks++; if (int_sync_o !== 6'd0) begin failures++; $display("FAIL int_sync1 got=%h exp=00", int_sync_o); end
    tick();
    checks++; if (int_sync_o !== 6'd1) begin failures++; $display("FAIL int_sync2 got=%h exp=01", int_sync_o); end
    #1;
    checks++; if (mem_cancel_o !== 1'b0) begin failures++; $display("FAIL int_bubble_cancel got=%b exp=0", mem_cancel_o); end
    tick();
    checks++; if (exccode_o !== 5'h10) begin failures++; $display("FAIL int_bubble_code got=%h exp=10", exccode_o); end
    tick();
    // First valid instruction also carries a load fault: interrupt wins, badvaddr untouched.
    inst_valid_i = 1; pc_i = 32'h3000; exc_load_adel_i = 1; mem_addr_i = 32'hdead_beef;
    #1;
    checks++; if (mem_cancel_o !== 1'b1) begin failures++; $display("FAIL int_cancel got=%b exp=1", mem_cancel_o); end
    tick();
    checks++; if (exccode_o !== 5'h00) begin failures++; $display("FAIL int_code got=%h exp=00", exccode_o); end
    checks++; if (pc_o !== 32'h3000) begin failures++; $display("FAIL int_pc got=%h exp=3000", pc_o); end
    checks++; if (badvaddr_o !== 32'h2003) begin failures++; $display("FAIL int_bad got=%h exp=2003", badvaddr_o); end
    clear_inputs();
    repeat (3) tick();
  endtask

  task automatic test_int_forward();
    clear_inputs();
    cp0_status_i = 32'h0000_0401;
    int_raw_i = 6'b000001;
    repeat (3) tick();
    inst_valid_i = 1; pc_i = 32'h4000;
    cp0_we_i = 1; cp0_waddr_i = 5'd12; cp0_wdata_i = 32'h0000_0400;
    #1;
    checks++; if (mem_cancel_o !== 1'b0) begin failures++; $display("FAIL fwd_st_cancel got=%b exp=0", mem_cancel_o); end
    tick();
    checks++; if (exccode_o !== 5'h10) begin failures++; $display("FAIL fwd_st_code got=%h exp=10", exccode_o); end
    cp0_we_i = 0;
    #1;
    checks++; if (mem_cancel_o !== 1'b1) begin failures++; $display("FAIL fwd_nowe_cancel got=%b exp=1", mem_cancel_o); end
    tick();
    checks++; if (exccode_o !== 5'h00) begin failures++; $display("FAIL fwd_nowe_code got=%h exp=00", exccode_o); end
    checks++; if (pc_o !== 32'h4000) begin failures++; $display("FAIL fwd_nowe_pc got=%h exp=4000", pc_o); end
    clear_inputs();
    repeat (3) tick();
    // Software interrupt raised only through the forwarded Cause write.
    cp0_status_i = 32'h0000_0101;
    cp0_we_i = 1; cp0_waddr_i = 5'd13; cp0_wdata_i = 32'h0000_0100;
    inst_valid_i = 1; pc_i = 32'h4100;
    #1;
    checks++; if (mem_cancel_o !== 1'b1) begin failures++; $display("FAIL fwd_ca_cancel got=%b exp=1", mem_cancel_o); end
    tick();
    checks++; if (exccode_o !== 5'h00) begin failures++; $display("FAIL fwd_ca_code got=%h exp=00", exccode_o); end
    clear_inputs();
    repeat (3) tick();
  endtask

  task automatic test_eret();
    clear_inputs();
    cp0_status_i = 32'h0000_0401;
    inst_valid_i = 1; pc_i = 32'h5000; eret_i = 1;
    #1;
    checks++; if (mem_cancel_o !== 1'b1) begin failures++; $display("FAIL eret_cancel got=%b exp=1", mem_cancel_o); end
    tick();
    checks++; if (exccode_o !== 5'h11) begin failures++; $display("FAIL eret_code got=%h exp=11", exccode_o); end
    eret_i = 0; int_raw_i = 6'b000001; pc_i = 32'h5004;
    tick();
    checks++; if (exccode_o !== 5'h10) begin failures++; $display("FAIL eret_pulse got=%h exp=10", exccode_o); end
    tick();
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL eret_busy got=%b exp=0", busy_o); end
    #1;
    checks++; if (mem_cancel_o !== 1'b0) begin failures++; $display("FAIL eret_blank_cancel got=%b exp=0", mem_cancel_o); end
    tick();
    checks++; if (exccode_o !== 5'h10) begin failures++; $display("FAIL eret_blank_code got=%h exp=10", exccode_o); end
    #1;
    checks++; if (mem_cancel_o !== 1'b1) begin failures++; $display("FAIL eret_unblank_cancel got=%b exp=1", mem_cancel_o); end
    tick();
    checks++; if (exccode_o !== 5'h00) begin failures++; $display("FAIL eret_int_code got=%h exp=00", exccode_o); end
    clear_inputs();
    repeat (3) tick();
    // Fault beside ERET: fault reported, no blanking window afterwards.
    cp0_status_i = 32'h0000_0401;
    inst_valid_i = 1; pc_i = 32'h6001; exc_fetch_adel_i = 1; eret_i = 1;
    tick();
    checks++; if (exccode_o !== 5'h04) begin failures++; $display("FAIL feret_code got=%h exp=04", exccode_o); end
    checks++; if (badvaddr_o !== 32'h6001) begin failures++; $display("FAIL feret_bad got=%h exp=6001", badvaddr_o); end
    exc_fetch_adel_i = 0; eret_i = 0; int_raw_i = 6'b000001; pc_i = 32'h6004;
    repeat (2) tick();
    #1;
    checks++; if (mem_cancel_o !== 1'b1) begin failures++; $display("FAIL feret_noblank got=%b exp=1", mem_cancel_o); end
    tick();
    checks++; if (exccode_o !== 5'h00) begin failures++; $display("FAIL feret_int_code got=%h exp=00", exccode_o); end
    clear_inputs();
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_squash();
    clear_inputs();
    inst_valid_i = 1; pc_i = 32'h7000; exc_ov_i = 1;
    tick();
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL rsq_pre_busy got=%b exp=1", busy_o); end
    rst_n = 0;
    clear_inputs();
    tick();
    rst_n = 1;
    #1;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rsq_busy got=%b exp=0", busy_o); end
    checks++; if (exccode_o !== 5'h10) begin failures++; $display("FAIL rsq_code got=%h exp=10", exccode_o); end
    checks++; if (badvaddr_o !== 32'd0) begin failures++; $display("FAIL rsq_bad got=%h exp=0", badvaddr_o); end
    inst_valid_i = 1; pc_i = 32'h7100; exc_ov_i = 1;
    tick();
    checks++; if (exccode_o !== 5'h0c) begin failures++; $display("FAIL rsq_newrep got=%h exp=0c", exccode_o); end
    clear_inputs();
    repeat (3) tick();
  endtask

  task automatic test_random();
    logic [5:0]  raw_hist[$];
    int          sq_left;
    int          blank_left;
    logic [31:0] exp_bad;
    logic [5:0]  sync_now;
    logic [31:0] st;
    logic [1:0]  swip;
    logic        pend;
    logic [4:0]  code;
    logic        bad_we;
    logic [31:0] bad;
    logic        exp_cancel;

    rst_n = 0;
    clear_inputs();
    repeat (2) tick();
    rst_n = 1;
    sq_left = 0; blank_left = 0; exp_bad = 0;
    raw_hist.delete();

    for (int cyc = 0; cyc < 400; cyc++) begin
      inst_valid_i     = ($urandom % 4) != 0;
      pc_i             = $urandom;
      in_delay_i       = $urandom % 2;
      mem_addr_i       = $urandom;
      exc_fetch_adel_i = ($urandom % 10) == 0;
      exc_ri_i         = ($urandom % 10) == 0;
      exc_ov_i         = ($urandom % 10) == 0;
      exc_syscall_i    = ($urandom % 10) == 0;
      exc_break_i      = ($urandom % 10) == 0;
      exc_load_adel_i  = ($urandom % 10) == 0;
      exc_store_ades_i = ($urandom % 10) == 0;
      eret_i           = ($urandom % 6) == 0;
      if (($urandom % 5) == 0) int_raw_i[$urandom % 6] = ~int_raw_i[$urandom % 6];
      if (($urandom % 8) == 0) begin
        cp0_status_i    = $urandom;
        cp0_status_i[0] = ($urandom % 4) != 0;
        cp0_status_i[1] = ($urandom % 5) == 0;
      end
      cp0_cause_i = ($urandom % 6 == 0) ? $urandom : 32'd0;
      cp0_we_i    = ($urandom % 5) == 0;
      cp0_waddr_i = ($urandom % 2 == 0) ? 5'(12 + ($urandom % 2)) : 5'($urandom);
      cp0_wdata_i = $urandom;

      sync_now = (raw_hist.size() >= SYNC_STAGES) ? raw_hist[raw_hist.size() - SYNC_STAGES] : 6'd0;
      st   = (cp0_we_i && cp0_waddr_i == 5'd12) ? cp0_wdata_i : cp0_status_i;
      swip = (cp0_we_i && cp0_waddr_i == 5'd13) ? cp0_wdata_i[9:8] : cp0_cause_i[9:8];
      pend = st[0] && !st[1] && (({sync_now, swip} & st[15:8]) != 8'd0) && (blank_left == 0);

      code = 5'h10; bad_we = 0; bad = 0;
      if (sq_left == 0 && inst_valid_i) begin
        if (pend) code = 5'h00;
        else if (exc_fetch_adel_i) begin code = 5'h04; bad_we = 1; bad = pc_i; end
        else if (exc_ri_i) code = 5'h0a;
        else if (exc_ov_i) code = 5'h0c;
        else if (exc_syscall_i) code = 5'h08;
        else if (exc_break_i) code = 5'h09;
        else if (exc_load_adel_i) begin code = 5'h04; bad_we = 1; bad = mem_addr_i; end
        else if (exc_store_ades_i) begin code = 5'h05; bad_we = 1; bad = mem_addr_i; end
        else if (eret_i) code = 5'h11;
      end
      exp_cancel = (code != 5'h10) || (sq_left > 0);

      #1;
      checks++; if (mem_cancel_o !== exp_cancel) begin failures++; $display("FAIL rnd_cancel cyc=%0d got=%b exp=%b", cyc, mem_cancel_o, exp_cancel); end
      checks++; if (busy_o !== (sq_left > 0)) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy_o, sq_left > 0); end
      checks++; if (int_sync_o !== sync_now) begin failures++; $display("FAIL rnd_sync cyc=%0d got=%h exp=%h", cyc, int_sync_o, sync_now); end
      tick();

      raw_hist.push_back(int_raw_i);
      if (raw_hist.size() > 8) void'(raw_hist.pop_front());
      if (bad_we) exp_bad = bad;
      if (code != 5'h10) sq_left = SQUASH_CYCLES;
      else if (sq_left > 0) sq_left--;
      if (code == 5'h11) blank_left = ERET_BLANK;
      else if (blank_left > 0) blank_left--;

      checks++; if (exccode_o !== code) begin failures++; $display("FAIL rnd_code cyc=%0d got=%h exp=%h", cyc, exccode_o, code); end
      checks++; if (pc_o !== pc_i) begin failures++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", cyc, pc_o, pc_i); end
      checks++; if (in_delay_o !== in_delay_i) begin failures++; $display("FAIL rnd_dly cyc=%0d got=%b exp=%b", cyc, in_delay_o, in_delay_i); end
      checks++; if (badvaddr_o !== exp_bad) begin failures++; $display("FAIL rnd_bad cyc=%0d got=%h exp=%h", cyc, badvaddr_o, exp_bad); end
    end
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    test_reset();
    test_overflow();
    test_load_adel_delay();
    test_interrupt();
    test_int_forward();
    test_eret();
    test_reset_mid_squash();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
